sdram_port_arbiter: RTL

//  Shares the single board SDRAM controller between three guest requesters:

---
 rtl/sdram_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter (video > ioctl > cpu, with CPU starvation guard) in front of
// a single-outstanding SDRAM controller req/ready port, with a WAIT timeout.
module sdram_port_arbiter #(
  parameter int AW         = 24,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          io_req,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  input  logic          err_clr,
  output logic [1:0]    dbg_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = 8;

  // Handshake: a requester raises req (level) with stable addr/data and keeps
  // it until its 1-cycle ack; toward the controller mem_req is a 1-cycle pulse
  // and mem_ready a 1-cycle completion pulse, honoured only in S_WAIT.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_IO, OWN_CPU} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, grant_sel;
  logic          grant, done, tmo_hit;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [TW-1:0] tmo_cnt;

  assign mem_req   = (state == S_ISSUE);
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_sel  = owner;
    starve_nxt = starve_cnt;
    done       = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (vid_req || io_req || cpu_req) begin
          grant     = 1'b1;
          state_nxt = S_ISSUE;
          if (cpu_req && starve_cnt == SW'(STARVE_MAX)) grant_sel = OWN_CPU;
          else if (vid_req)                             grant_sel = OWN_VID;
          else if (io_req)                              grant_sel = OWN_IO;
          else                                          grant_sel = OWN_CPU;
          // Count only grants the CPU actually competed for and lost.
          if (grant_sel == OWN_CPU)
            starve_nxt = '0;
          else if (cpu_req && starve_cnt != SW'(STARVE_MAX))
            starve_nxt = starve_cnt + SW'(1);
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_ready) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT)) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      owner      <= OWN_VID;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      vid_ack    <= 1'b0;
      io_ack     <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      vid_ack    <= 1'b0;
      io_ack     <= 1'b0;
      cpu_ack    <= 1'b0;

      if (grant) begin
        owner <= grant_sel;
        case (grant_sel)
          OWN_VID: begin
            mem_we    <= 1'b0;
            mem_addr  <= vid_addr;
            mem_wdata <= '0;
          end
          OWN_IO: begin
            mem_we    <= 1'b1;
            mem_addr  <= io_addr;
            mem_wdata <= io_wdata;
          end
          default: begin
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end
        endcase
      end

      if (state == S_ISSUE)     tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TW'(1);

      // A timed-out read returns zero data; writes never touch rdata.
      if (done || tmo_hit) begin
        case (owner)
          OWN_VID: begin
            vid_ack   <= 1'b1;
            vid_rdata <= done ? mem_rdata : '0;
          end
          OWN_IO: io_ack <= 1'b1;
          default: begin
            cpu_ack <= 1'b1;
            if (!mem_we) cpu_rdata <= done ? mem_rdata : '0;
          end
        endcase
      end

      if (tmo_hit)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule
